// File: rtl/aes_byte_serializer.sv
// Byte serializer for the AES core output side: accepts a 128-bit block over
// valid/ready and streams it MSB byte first, one byte per clock. A pending
// slot lets the next block load while the current block drains, so
// back-to-back blocks leave with no idle cycle between them.
module aes_byte_serializer #(
  parameter int BLOCK_W = 128,
  parameter int BYTE_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [BLOCK_W-1:0] BlockIn,
  input  logic               BlockValid,
  output logic               BlockReady,
  output logic [BYTE_W-1:0]  ByteOut,
  output logic               ByteValid,
  input  logic               ByteReady,
  output logic               ByteFirst,
  output logic               ByteLast,
  output logic               Busy
);

  localparam int NBYTES = BLOCK_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // EMPTY: nothing held; SEND: one block draining; SEND_FULL: draining with
  // a second block waiting in the pending slot.
  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    SEND      = 2'd1,
    SEND_FULL = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [BLOCK_W-1:0] shift_r, shift_s;
  logic [BLOCK_W-1:0] pending_r, pending_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;

  logic act_v_s;
  logic pend_v_s;
  logic accept_s;
  logic xfer_s;
  logic last_s;

  assign act_v_s  = (state_r != EMPTY);
  assign pend_v_s = (state_r == SEND_FULL);

  // Ready depends only on registered state (and reset), never on ByteReady.
  assign BlockReady = ~Reset & ~pend_v_s;
  assign accept_s   = BlockValid & BlockReady;
  assign xfer_s     = act_v_s & ByteReady;
  assign last_s     = (cnt_r == CNT_LAST);

  assign ByteOut   = shift_r[BLOCK_W-1 -: BYTE_W];
  assign ByteValid = act_v_s;
  assign ByteFirst = act_v_s & (cnt_r == CNT_ZERO);
  assign ByteLast  = act_v_s & last_s;
  assign Busy      = act_v_s | pend_v_s;

  // Next-state, datapath and counter decode for the two-slot buffer.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    pending_s = pending_r;
    cnt_s     = cnt_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          shift_s = BlockIn;
          cnt_s   = CNT_ZERO;
          state_s = SEND;
        end else begin
          state_s = EMPTY;
        end
      end
      SEND: begin
        if (xfer_s && last_s) begin
          // Last byte leaves: an incoming block goes straight to the shifter.
          cnt_s = CNT_ZERO;
          if (accept_s) begin
            shift_s = BlockIn;
            state_s = SEND;
          end else begin
            state_s = EMPTY;
          end
        end else begin
          if (xfer_s) begin
            shift_s = shift_r << BYTE_W;
            cnt_s   = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
          if (accept_s) begin
            pending_s = BlockIn;
            state_s   = SEND_FULL;
          end else begin
            state_s = SEND;
          end
        end
      end
      SEND_FULL: begin
        // No accept is possible here since BlockReady is low.
        if (xfer_s && last_s) begin
          shift_s = pending_r;
          cnt_s   = CNT_ZERO;
          state_s = SEND;
        end else if (xfer_s) begin
          shift_s = shift_r << BYTE_W;
          cnt_s   = cnt_r + CNT_ONE;
        end else begin
          state_s = SEND_FULL;
        end
      end
      default: begin
        state_s = EMPTY;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or pending block.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= EMPTY;
      shift_r   <= {BLOCK_W{1'b0}};
      pending_r <= {BLOCK_W{1'b0}};
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      pending_r <= pending_s;
      cnt_r     <= cnt_s;
    end
  end

endmodule

// File: tb/tb_aes_byte_serializer.sv
// Directed self-checking bench for aes_byte_serializer.
module tb_aes_byte_serializer;

  logic         Clk;
  logic         Reset;
  logic [127:0] BlockIn;
  logic         BlockValid;
  logic         BlockReady;
  logic [7:0]   ByteOut;
  logic         ByteValid;
  logic         ByteReady;
  logic         ByteFirst;
  logic         ByteLast;
  logic         Busy;

  int n_cmp;
  int n_bad;

  localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_B = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] BLK_C = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  aes_byte_serializer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BlockIn    (BlockIn),
    .BlockValid (BlockValid),
    .BlockReady (BlockReady),
    .ByteOut    (ByteOut),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .ByteFirst  (ByteFirst),
    .ByteLast   (ByteLast),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Hand-derived byte i of each test block.
  function automatic logic [7:0] exp_byte(input int blk, input int i);
    case (blk)
      0:       return 8'(i * 17);
      1:       return 8'(255 - i * 17);
      default: return 8'((i + 1) * 15);
    endcase
  endfunction

  task automatic run_bytes(input int blk, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check($sformatf("valid b%0d.%0d", blk, i), 32'(ByteValid), 32'd1);
      check($sformatf("byte b%0d.%0d", blk, i), 32'(ByteOut), 32'(exp_byte(blk, i)));
      check($sformatf("first b%0d.%0d", blk, i), 32'(ByteFirst), 32'(i == 0));
      check($sformatf("last b%0d.%0d", blk, i), 32'(ByteLast), 32'(i == 15));
      step();
    end
  endtask

  task automatic offer(input logic [127:0] blk);
    BlockIn    = blk;
    BlockValid = 1'b1;
  endtask

  initial begin
    int xfers;
    int idx;
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    BlockIn = 128'd0;
    BlockValid = 1'b0;
    ByteReady = 1'b1;
    step();
    check("rst ready", 32'(BlockReady), 32'd0);
    check("rst valid", 32'(ByteValid), 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst byte", 32'(ByteOut), 32'd0);
    check("rst first", 32'(ByteFirst), 32'd0);
    check("rst last", 32'(ByteLast), 32'd0);
    Reset = 1'b0;
    #1;
    check("idle ready", 32'(BlockReady), 32'd1);

    // 1: single block, 1-cycle latency.
    offer(BLK_A);
    step();
    BlockValid = 1'b0;
    check("t1 busy", 32'(Busy), 32'd1);
    run_bytes(0, 0, 15);
    check("t1 idle", 32'(ByteValid), 32'd0);

    // 2: two blocks back-to-back, no gap.
    offer(BLK_A);
    step();
    offer(BLK_B);
    run_bytes(0, 0, 0);
    BlockValid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check("t2 ready held", 32'(BlockReady), 32'd0);
      run_bytes(0, i, i);
    end
    check("t2 ready free", 32'(BlockReady), 32'd1);
    run_bytes(1, 0, 15);
    check("t2 idle", 32'(ByteValid), 32'd0);

    // 3: backpressure for 3 cycles on byte 55.
    offer(BLK_A);
    step();
    BlockValid = 1'b0;
    xfers = 0;
    for (int cyc = 0; cyc <= 18; cyc++) begin
      ByteReady = !(cyc >= 5 && cyc <= 7);
      idx = (cyc < 5) ? cyc : ((cyc <= 8) ? 5 : cyc - 3);
      check("t3 valid", 32'(ByteValid), 32'd1);
      check("t3 byte", 32'(ByteOut), 32'(exp_byte(0, idx)));
      check("t3 last", 32'(ByteLast), 32'(idx == 15));
      if (ByteValid && ByteReady) xfers++;
      step();
    end
    ByteReady = 1'b1;
    check("t3 xfers", 32'(xfers), 32'd16);
    check("t3 idle", 32'(ByteValid), 32'd0);

    // 4: third block held off while SEND_FULL.
    offer(BLK_A);
    step();
    offer(BLK_B);
    run_bytes(0, 0, 0);
    offer(BLK_C);
    for (int i = 1; i <= 15; i++) begin
      check("t4 ready held", 32'(BlockReady), 32'd0);
      run_bytes(0, i, i);
    end
    check("t4 ready after ff", 32'(BlockReady), 32'd1);
    run_bytes(1, 0, 0);
    check("t4 c pending", 32'(BlockReady), 32'd0);
    BlockValid = 1'b0;
    run_bytes(1, 1, 15);
    run_bytes(2, 0, 15);
    check("t4 idle", 32'(ByteValid), 32'd0);

    // 5: reset mid-block at byte 77.
    offer(BLK_A);
    offer(BLK_A);
    step();
    offer(BLK_B);
    run_bytes(0, 0, 0);
    BlockValid = 1'b0;
    run_bytes(0, 1, 6);
    check("t5 at 77", 32'(ByteOut), 32'h77);
    Reset = 1'b1;
    #1;
    check("t5 rst valid", 32'(ByteValid), 32'd0);
    check("t5 rst ready", 32'(BlockReady), 32'd0);
    check("t5 rst busy", 32'(Busy), 32'd0);
    step();
    Reset = 1'b0;
    #1;
    check("t5 rel ready", 32'(BlockReady), 32'd1);
    check("t5 rel valid", 32'(ByteValid), 32'd0);
    step();
    check("t5 no stale", 32'(ByteValid), 32'd0);
    offer(BLK_B);
    step();
    BlockValid = 1'b0;
    run_bytes(1, 0, 15);
    check("t5 idle", 32'(ByteValid), 32'd0);

    // 6: last-byte xfer in SEND coincides with accept.
    offer(BLK_A);
    step();
    BlockValid = 1'b0;
    run_bytes(0, 0, 14);
    offer(BLK_B);
    check("t6 ready", 32'(BlockReady), 32'd1);
    run_bytes(0, 15, 15);
    BlockValid = 1'b0;
    run_bytes(1, 0, 15);
    check("t6 idle", 32'(ByteValid), 32'd0);
    check("t6 busy", 32'(Busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
